// File: rtl/prbs_rx_pkg.sv
// Shared types and constants for the PRBS-15 pattern receiver.
// The debug struct exposes FSM state, byte index and next PRBS history.
package prbs_rx_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SEED  = 2'd1,
    CHECK = 2'd2
  } rx_state_t;

  localparam int PRBS15_TAP_A = 14;
  localparam int PRBS15_TAP_B = 13;
  localparam int PRBS_LEN     = 15;

  localparam logic [31:0] DEFAULT_PATTERN = 32'hABCD_EFCD;

  typedef struct packed {
    rx_state_t            state;
    logic [1:0]           byte_idx;
    logic [PRBS_LEN-1:0]  hist_next;
  } rx_dbg_t;

endpackage

// File: rtl/prbs15_byte_checker.sv
// PRBS-15 (x^15+x^14+1) byte-wide self-synchronising checker.
// Holds the 15-bit bit history and counts the mismatching bits in one byte.
module prbs15_byte_checker
  import prbs_rx_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                seed_en,
  input  logic                check_en,
  input  logic [7:0]          data,
  output logic [3:0]          byte_err,
  output logic [PRBS_LEN-1:0] hist_next
);

  logic [PRBS_LEN-1:0] hist_q;
  logic [PRBS_LEN-1:0] h_w;
  logic                pred_w;

  // The received bits, not the predicted ones, enter the history in both modes.
  always_comb begin
    hist_next = hist_q;
    if (seed_en || check_en) begin
      hist_next = {hist_q[PRBS_LEN-9:0], data};
    end
  end

  always_comb begin
    byte_err = '0;
    h_w      = hist_q;
    pred_w   = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      pred_w   = h_w[PRBS15_TAP_A] ^ h_w[PRBS15_TAP_B];
      byte_err = byte_err + {3'b000, data[i] ^ pred_w};
      h_w      = {h_w[PRBS_LEN-2:0], data[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_next;
    end
  end

endmodule

// File: rtl/prbs_pattern_checker.sv
// Receive-side header lock + PRBS-15 payload bit-error counter.
// Input handshake: a byte is consumed on every rising edge where data_valid=1; there is no back-pressure.
module prbs_pattern_checker
  import prbs_rx_pkg::*;
#(
  parameter logic [31:0] PATTERN = DEFAULT_PATTERN,
  parameter int          ERR_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clear,
  input  logic             data_valid,
  input  logic [7:0]       in,
  input  logic [7:0]       n,
  output logic [7:0]       rep_count,
  output logic             pattern_locked,
  output logic             prbs_sync,
  output logic [ERR_W-1:0] err_count,
  output rx_dbg_t          dbg
);

  rx_state_t        state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       rep_q, rep_d;
  logic             locked_q, locked_d;
  logic             sync_q, sync_d;
  logic             seed_cnt_q, seed_cnt_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic                soft_rst;
  logic                seed_en, check_en;
  logic [3:0]          byte_err;
  logic [PRBS_LEN-1:0] hist_next;
  logic [7:0]          exp_byte;
  logic [7:0]          n_eff;
  logic [ERR_W:0]      err_sum;

  assign soft_rst = RST | clear;
  assign n_eff    = (n == 8'd0) ? 8'd1 : n;
  assign err_sum  = {1'b0, err_q} + {1'b0, {(ERR_W-4){1'b0}}, byte_err};

  always_comb begin
    case (idx_q)
      2'd0:    exp_byte = PATTERN[31:24];
      2'd1:    exp_byte = PATTERN[23:16];
      2'd2:    exp_byte = PATTERN[15:8];
      default: exp_byte = PATTERN[7:0];
    endcase
  end

  prbs15_byte_checker u_prbs (
    .clk       (CLK),
    .rst       (soft_rst),
    .seed_en   (seed_en),
    .check_en  (check_en),
    .data      (in),
    .byte_err  (byte_err),
    .hist_next (hist_next)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rep_d      = rep_q;
    locked_d   = locked_q;
    sync_d     = sync_q;
    seed_cnt_d = seed_cnt_q;
    err_d      = err_q;
    seed_en    = 1'b0;
    check_en   = 1'b0;
    if (data_valid) begin
      case (state_q)
        HUNT: begin
          if (in == exp_byte) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              rep_d = rep_q + 8'd1;
              if (rep_d >= n_eff) begin
                locked_d = 1'b1;
                state_d  = SEED;
              end
            end
          end else begin
            // A broken run restarts; the offending byte may itself open a new word.
            rep_d = '0;
            idx_d = (in == PATTERN[31:24]) ? 2'd1 : 2'd0;
          end
        end
        SEED: begin
          seed_en    = 1'b1;
          seed_cnt_d = 1'b1;
          if (seed_cnt_q) begin
            sync_d  = 1'b1;
            state_d = CHECK;
          end
        end
        CHECK: begin
          check_en = 1'b1;
          err_d    = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (soft_rst) begin
      state_q    <= HUNT;
      idx_q      <= '0;
      rep_q      <= '0;
      locked_q   <= 1'b0;
      sync_q     <= 1'b0;
      seed_cnt_q <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rep_q      <= rep_d;
      locked_q   <= locked_d;
      sync_q     <= sync_d;
      seed_cnt_q <= seed_cnt_d;
      err_q      <= err_d;
    end
  end

  assign rep_count      = rep_q;
  assign pattern_locked = locked_q;
  assign prbs_sync      = sync_q;
  assign err_count      = err_q;
  assign dbg            = '{state: state_q, byte_idx: idx_q, hist_next: hist_next};

endmodule
